mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Bus between the E-stage pipeline logic and the multiply/divide unit.
interface mult_div_unit_if;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        D_md;
    logic        busy;
    logic        start;
    logic        md_stall;
    logic [31:0] md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output op, A, B, flush, D_md,
        input  busy, start, md_stall, md_out, HI, LO
    );

    modport slave (
        input  op, A, B, flush, D_md,
        output busy, start, md_stall, md_out, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for a 5-stage pipeline.
// Results are staged at issue and committed to HI/LO when the busy countdown expires.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  md
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [CW-1:0] MUL_CYC = CW'(5);
    localparam logic [CW-1:0] DIV_CYC = CW'(10);

    logic [1:0]      state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [W-1:0]    hi, hi_nx, lo, lo_nx;
    logic [W-1:0]    stg_hi, stg_hi_nx, stg_lo, stg_lo_nx;
    logic            busy_q;

    logic [3:0]      op_d;
    logic            is_mul, is_div;
    logic [2*W-1:0]  prod;
    logic            sgn;
    logic [W-1:0]    a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Undefined opcodes collapse to "none"
    assign op_d   = (md.op > OP_MTLO) ? 4'd0 : md.op;
    assign is_mul = (op_d == OP_MULT) || (op_d == OP_MULTU);
    assign is_div = (op_d == OP_DIV)  || (op_d == OP_DIVU);

    assign md.start    = (is_mul || is_div) && !md.flush;
    assign md.md_stall = md.D_md && (busy_q || md.start);
    assign md.busy     = busy_q;
    assign md.HI       = hi;
    assign md.LO       = lo;

    always_comb begin
        md.md_out = '0;
        case (op_d)
            OP_MFHI: md.md_out = hi;
            OP_MFLO: md.md_out = lo;
            default: md.md_out = '0;
        endcase
    end

    // Sign-magnitude division: truncates toward zero, remainder follows the dividend
    always_comb begin
        sgn   = (op_d == OP_DIV);
        a_mag = (sgn && md.A[W-1]) ? W'(-md.A) : md.A;
        b_mag = (sgn && md.B[W-1]) ? W'(-md.B) : md.B;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (sgn && (md.A[W-1] ^ md.B[W-1])) ? W'(-q_mag) : q_mag;
        rem = (sgn && md.A[W-1]) ? W'(-r_mag) : r_mag;
        if (op_d == OP_MULT)
            prod = $signed({{W{md.A[W-1]}}, md.A}) * $signed({{W{md.B[W-1]}}, md.B});
        else
            prod = {{W{1'b0}}, md.A} * {{W{1'b0}}, md.B};
    end

    // Next-state and HI/LO/staging update
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_nx     = hi;
        lo_nx     = lo;
        stg_hi_nx = stg_hi;
        stg_lo_nx = stg_lo;
        case (state)
            IDLE: begin
                if (!md.flush) begin
                    if (is_mul) begin
                        stg_hi_nx = prod[2*W-1:W];
                        stg_lo_nx = prod[W-1:0];
                        state_nx  = MUL;
                        cnt_nx    = MUL_CYC;
                    end else if (is_div) begin
                        // Divide by zero commits the current HI/LO back unchanged
                        stg_hi_nx = (md.B == '0) ? hi : rem;
                        stg_lo_nx = (md.B == '0) ? lo : quo;
                        state_nx  = DIV;
                        cnt_nx    = DIV_CYC;
                    end else if (op_d == OP_MTHI) begin
                        hi_nx = md.A;
                    end else if (op_d == OP_MTLO) begin
                        lo_nx = md.A;
                    end
                end
            end
            MUL, DIV: begin
                cnt_nx = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    cnt_nx   = '0;
                    hi_nx    = stg_hi;
                    lo_nx    = stg_lo;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            stg_hi <= '0;
            stg_lo <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
            stg_hi <= stg_hi_nx;
            stg_lo <= stg_lo_nx;
            busy_q <= (state_nx != IDLE);
        end
    end
endmodule
